// File: rtl/multicore_cpu_1_cpu_mult_combine.sv
// Two-stage combiner that folds four 16x16 partial products into a 64-bit product.
// S1 sums the middle partial products; S2 assembles and holds the final result.
module multicore_cpu_1_cpu_mult_combine #(
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_src1_signed,
   input  logic             in_src2_signed,
   input  logic [31:0]      in_p1,
   input  logic [31:0]      in_p2,
   input  logic [31:0]      in_p3,
   input  logic [31:0]      in_p4,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_lo,
   output logic [31:0]      out_hi,
   output logic [TAG_W-1:0] out_tag
);

   logic             s1_valid_reg;
   logic [31:0]      s1_p1_reg;
   logic [31:0]      s1_p4_reg;
   logic [33:0]      s1_mid_reg;
   logic [TAG_W-1:0] s1_tag_reg;

   logic             s2_valid_reg;
   logic [63:0]      s2_prod_reg;
   logic [TAG_W-1:0] s2_tag_reg;

   logic             s2_adv;
   logic             s1_adv;
   logic             in_fire;
   logic [33:0]      mid_next;
   logic [63:0]      prod_next;

   assign s2_adv   = !s2_valid_reg || out_ready;
   assign s1_adv   = !s1_valid_reg || s2_adv;
   assign in_ready = s1_adv && !flush;
   assign in_fire  = in_valid && in_ready;

   // p2/p3 carry the signedness of the high half they multiply by
   assign mid_next = {{2{in_src2_signed & in_p2[31]}}, in_p2}
                   + {{2{in_src1_signed & in_p3[31]}}, in_p3};

   assign prod_next = {s1_p4_reg, 32'b0}
                    + {{14{s1_mid_reg[33]}}, s1_mid_reg, 16'b0}
                    + {32'b0, s1_p1_reg};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_reg <= 1'b0;
         s1_p1_reg    <= '0;
         s1_p4_reg    <= '0;
         s1_mid_reg   <= '0;
         s1_tag_reg   <= '0;
         s2_valid_reg <= 1'b0;
         s2_prod_reg  <= '0;
         s2_tag_reg   <= '0;
      end else if (flush) begin
         s1_valid_reg <= 1'b0;
         s2_valid_reg <= 1'b0;
      end else begin
         if (s1_adv) begin
            s1_valid_reg <= in_valid;
         end
         if (in_fire) begin
            s1_p1_reg  <= in_p1;
            s1_p4_reg  <= in_p4;
            s1_mid_reg <= mid_next;
            s1_tag_reg <= in_tag;
         end
         if (s2_adv) begin
            s2_valid_reg <= s1_valid_reg;
            // an empty S1 leaves the last result in place
            if (s1_valid_reg) begin
               s2_prod_reg <= prod_next;
               s2_tag_reg  <= s1_tag_reg;
            end
         end
      end
   end

   assign out_valid = s2_valid_reg;
   assign out_lo    = s2_prod_reg[31:0];
   assign out_hi    = s2_prod_reg[63:32];
   assign out_tag   = s2_tag_reg;

endmodule

// File: tb/tb_multicore_cpu_1_cpu_mult_combine.sv
// Scoreboard bench: directed cases, backpressure, flush, reset, then random traffic
// checked against a full-width multiply of the original operands.
module tb_multicore_cpu_1_cpu_mult_combine;
   localparam int TAG_W = 5;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic             in_src1_signed = 1'b0;
   logic             in_src2_signed = 1'b0;
   logic [31:0]      in_p1 = '0, in_p2 = '0, in_p3 = '0, in_p4 = '0;
   logic [TAG_W-1:0] in_tag = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [31:0]      out_lo, out_hi;
   logic [TAG_W-1:0] out_tag;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [31:0]      hi;
      logic [31:0]      lo;
   } exp_t;

   exp_t cur_exp;
   exp_t scb[$];
   int   checks = 0;
   int   failures = 0;

   multicore_cpu_1_cpu_mult_combine #(.TAG_W(TAG_W)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_src1_signed(in_src1_signed), .in_src2_signed(in_src2_signed),
      .in_p1(in_p1), .in_p2(in_p2), .in_p3(in_p3), .in_p4(in_p4), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_lo(out_lo), .out_hi(out_hi), .out_tag(out_tag)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic set_vec(input logic [31:0] p1, input logic [31:0] p2, input logic [31:0] p3,
                          input logic [31:0] p4, input logic s1s, input logic s2s,
                          input logic [TAG_W-1:0] tag, input logic [31:0] hi, input logic [31:0] lo);
      in_p1 = p1; in_p2 = p2; in_p3 = p3; in_p4 = p4;
      in_src1_signed = s1s; in_src2_signed = s2s; in_tag = tag;
      cur_exp = '{tag: tag, hi: hi, lo: lo};
      in_valid = 1'b1;
   endtask

   // Reference: split random operands into halves, form the partial products,
   // and expect the plain 64-bit product of the extended operands.
   task automatic gen_random();
      logic [31:0] a, b;
      logic        sa, sbb;
      logic [63:0] al, ah, bl, bh, t1, t2, t3, t4, ea, eb, prod;
      a = $urandom; b = $urandom;
      sa = 1'($urandom_range(0, 1)); sbb = 1'($urandom_range(0, 1));
      al = {48'b0, a[15:0]};
      bl = {48'b0, b[15:0]};
      ah = sa  ? {{48{a[31]}}, a[31:16]} : {48'b0, a[31:16]};
      bh = sbb ? {{48{b[31]}}, b[31:16]} : {48'b0, b[31:16]};
      t1 = al * bl; t2 = al * bh; t3 = ah * bl; t4 = ah * bh;
      ea = sa  ? {{32{a[31]}}, a} : {32'b0, a};
      eb = sbb ? {{32{b[31]}}, b} : {32'b0, b};
      prod = ea * eb;
      set_vec(t1[31:0], t2[31:0], t3[31:0], t4[31:0], sa, sbb,
              TAG_W'($urandom), prod[63:32], prod[31:0]);
   endtask

   // Entered and left at posedge+1.
   task automatic wait_accept();
      bit ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      if (!ok) check("accept_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Monitor: scoreboard pop/push and hold-stability on the falling edge.
   initial begin
      logic stall = 1'b0;
      exp_t held, e;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            scb.delete();
            stall = 1'b0;
         end else begin
            if (stall)
               check("hold", {out_valid, out_tag, out_hi, out_lo}, {1'b1, held});
            if (out_valid && out_ready && !flush) begin
               $display("tb: result tag=%0d hi=%h lo=%h", out_tag, out_hi, out_lo);
               if (scb.size() == 0) begin
                  check("unexpected_result", {1'b1, out_tag, out_hi, out_lo}, 0);
               end else begin
                  e = scb.pop_front();
                  check("result", {out_tag, out_hi, out_lo}, e);
               end
            end
            if (in_valid && in_ready) scb.push_back(cur_exp);
            if (flush) scb.delete();
            stall = out_valid && !out_ready && !flush;
            held = '{tag: out_tag, hi: out_hi, lo: out_lo};
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit pending = 1'b0;
      #23 reset_n = 1'b1;
      @(posedge clk); #1;
      check("reset_in_ready", in_ready, 1);
      check("reset_outputs", {out_valid, out_tag, out_hi, out_lo}, 0);

      // Directed products with latency check on the first one
      out_ready = 1'b1;
      set_vec(32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 1'b0, 1'b0, 5'd3,
              32'hFFFFFFFE, 32'h00000001);
      wait_accept();
      check("latency_s1", out_valid, 0);
      @(posedge clk); #1;
      check("latency_s2", {out_valid, out_tag}, {1'b1, 5'd3});
      set_vec(32'hFFFE0001, 32'hFFFF0001, 32'hFFFF0001, 32'h00000001, 1'b1, 1'b1, 5'd7,
              32'h00000000, 32'h00000001);
      wait_accept();
      set_vec(32'h0002FFFA, 32'h00000000, 32'hFFFFFFFD, 32'h00000000, 1'b1, 1'b0, 5'd9,
              32'hFFFFFFFF, 32'hFFFFFFFA);
      wait_accept();
      repeat (3) @(posedge clk);
      #1;

      // Backpressure: two accepted, third held off
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         gen_random(); in_tag = TAG_W'(i); cur_exp.tag = TAG_W'(i);
         wait_accept();
      end
      gen_random(); in_tag = 5'd2; cur_exp.tag = 5'd2;
      repeat (3) begin
         @(negedge clk);
         check("bp_in_ready", in_ready, 0);
         check("bp_hold_tag", {out_valid, out_tag}, {1'b1, 5'd0});
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_order", {out_valid, out_tag}, {1'b1, TAG_W'(i)});
         @(posedge clk); #1;
         if (i == 0) in_valid = 1'b0;
      end

      // Flush with both stages full and an input on offer
      out_ready = 1'b0;
      repeat (2) begin gen_random(); wait_accept(); end
      gen_random();
      flush = 1'b1;
      @(negedge clk);
      check("flush_in_ready", in_ready, 0);
      @(posedge clk); #1;
      check("flush_out_valid", out_valid, 0);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      gen_random(); wait_accept();
      repeat (3) @(posedge clk);
      #1;
      check("flush_drain", scb.size(), 0);

      // Asynchronous reset with operations in flight
      out_ready = 1'b0;
      repeat (2) begin gen_random(); wait_accept(); end
      #2 reset_n = 1'b0;
      #1 check("rst_async", {out_valid, out_tag, out_hi, out_lo}, 0);
      #12 reset_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      repeat (4) begin
         @(negedge clk);
         check("rst_no_emit", out_valid, 0);
      end
      @(posedge clk); #1;

      // Random traffic with random backpressure and occasional flush
      for (int c = 0; c < 2000; c++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         flush = ($urandom_range(0, 49) == 0);
         if (!pending && $urandom_range(0, 3) != 0) begin
            gen_random();
            pending = 1'b1;
         end
         @(negedge clk);
         if (in_valid && in_ready) pending = 1'b0;
         @(posedge clk); #1;
         if (!pending) in_valid = 1'b0;
      end
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("final_drain", scb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multicore_cpu_1_cpu_mult_combine.md
MULTICORE_CPU_1_CPU_MULT_COMBINE -- requirements
Module: multicore_cpu_1_cpu_mult_combine

Interface
REQ-001 SHALL have parameter TAG_W, default 5: width of the destination tag that travels with each operation.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port flush, input, 1: synchronous discard of all in-flight operations.
REQ-005 SHALL have port in_valid, input, 1: partial-product set offered.
REQ-006 SHALL have port in_ready, output, 1: the set is accepted when in_valid and in_ready are both 1.
REQ-007 SHALL have port in_src1_signed, input, 1: src1 is treated as signed.
REQ-008 SHALL have port in_src2_signed, input, 1: src2 is treated as signed.
REQ-009 SHALL have ports in_p1, in_p2, in_p3, in_p4, input, 32 each: partial products.
- p1 = src1[15:0] x src2[15:0], unsigned.
- p2 = src1[15:0] x src2[31:16], signed per src2.
- p3 = src1[31:16] x src2[15:0], signed per src1.
- p4 = src1[31:16] x src2[31:16].
REQ-010 SHALL have port in_tag, input, TAG_W: opaque destination tag.
REQ-011 SHALL have port out_valid, output, 1: result present.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-013 SHALL have ports out_lo and out_hi, output, 32 each: bits [31:0] and [63:32] of the 64-bit product.
REQ-014 SHALL have port out_tag, output, TAG_W: tag of the presented result.

Function
REQ-015 SHALL be a two-stage pipeline, S1 and S2, each holding a valid bit, data and tag.
REQ-016 SHALL compute in S1 mid = ext(p2) + ext(p3) as a 34-bit signed value.
- ext(p2) sign-extends if in_src2_signed, otherwise zero-extends.
- ext(p3) sign-extends if in_src1_signed, otherwise zero-extends.
- S1 registers p1, p4, mid and the tag.
REQ-017 SHALL compute in S2 the product = {p4,32'b0} + (sext(mid) << 16) + zext(p1), modulo 2^64, and register it into out_hi:out_lo.
REQ-018 SHALL advance S2 when !S2.valid or out_ready.
REQ-019 SHALL advance S1 when !S1.valid or S2 advances.
REQ-020 SHALL drive in_ready = S1 advance condition and !flush; in_ready is combinational from out_ready.
REQ-021 SHALL present out_valid 2 cycles after acceptance when unstalled, and sustain 1 result per cycle while out_ready=1.
REQ-022 SHALL hold out_lo, out_hi and out_tag stable while out_valid=1 and out_ready=0.
REQ-023 SHALL, on flush=1, clear S1.valid and S2.valid at the next edge and not accept input that cycle; flush overrides a simultaneous result handshake and a simultaneous input offer.
REQ-024 SHALL neither drop nor duplicate results under any out_ready pattern, and SHALL deliver results in acceptance order.
REQ-025 SHALL leave data registers unchanged when their stage does not advance, and SHALL NOT update S2 from an empty S1.

Reset
REQ-026 SHALL, while reset_n=0, clear S1.valid and S2.valid and force out_valid=0, out_lo=0, out_hi=0 and out_tag=0, independent of clk.
REQ-027 SHALL drive in_ready=1 in the first cycle after reset_n deasserts, given flush=0.
REQ-028 SHALL discard an operation in flight when reset asserts, and SHALL NOT emit it after reset.

Verification
REQ-029 Unsigned 0xFFFFFFFF x 0xFFFFFFFF:
- Stimulus: p1..p4 all 0xFFFE0001, both signed flags 0, tag 3.
- Response: out_hi=0xFFFFFFFE, out_lo=0x00000001, out_tag=3, two cycles after acceptance.
REQ-030 Signed -1 x -1:
- Stimulus: p1=0xFFFE0001, p2=p3=0xFFFF0001, p4=0x00000001, both flags 1.
- Response: out_hi=0x00000000, out_lo=0x00000001.
REQ-031 Mixed -2 (signed) x 3 (unsigned):
- Stimulus: p1=0x0002FFFA, p2=0, p3=0xFFFFFFFD, p4=0, src1_signed=1, src2_signed=0.
- Response: out_hi=0xFFFFFFFF, out_lo=0xFFFFFFFA.
REQ-032 Backpressure:
- Stimulus: out_ready=0 while offering 3 back-to-back sets.
- Response: 2 are accepted, then in_ready=0 and outputs stay stable; on raising out_ready, the 3 results (tags 0,1,2) emerge on consecutive cycles in order.
REQ-033 Flush:
- Stimulus: flush=1 pulsed with S1 and S2 full and in_valid=1.
- Response: out_valid=0 next cycle, no input accepted that cycle, and a subsequent set completes normally.
REQ-034 Reset mid-operation:
- Stimulus: reset_n=0 asynchronously between edges with S1 full.
- Response: out_valid, out_lo, out_hi and out_tag go to 0 immediately, and nothing is emitted after release.
